// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register write arbiter.
package reg_write_arbiter_pkg;

  // Sequencer states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Operation encoding carried on the per-requester clr lines.
  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

endpackage

// File: rtl/reg_write_arbiter_pick.sv
// Combinational round-robin priority pick: first set request at or above ptr,
// wrapping modulo R. Reusable by any arbiter that keeps its own pointer.
module rr_priority_pick #(
  parameter  int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [R-1:0]  grant,
  output logic [IW-1:0] w,
  output logic          any_req
);

  localparam logic [IW:0] R_EXT = (IW+1)'(R);

  logic [IW-1:0] cand_idx [R];
  logic [R-1:0]  rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_rot
      logic [IW:0] sum;
      // Candidate gi is the requester gi positions above the pointer.
      assign sum          = {1'b0, ptr} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= R_EXT) ? IW'(sum - R_EXT) : sum[IW-1:0];
      assign rot_req[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  // Lowest rotated position wins; iterating downward lets it overwrite others.
  always_comb begin
    w       = '0;
    grant   = '0;
    any_req = |req;
    for (int k = R - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        w = cand_idx[k];
      end
    end
    if (any_req) begin
      grant[w] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin sequencer sharing one N-bit register between R requesters.
// Each grant produces one register-enable cycle followed by a one-cycle ack.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [R-1:0]    req,
  input  logic [R-1:0]    clr,
  input  logic [R*N-1:0]  wdata,
  output logic [R-1:0]    ack,
  output logic            reg_ce,
  output logic            reg_rst,
  output logic [N-1:0]    reg_d,
  output logic            busy,
  output logic [IW-1:0]   last_id
);

  localparam logic [R-1:0] ONE_HOT_0 = R'(1);

  state_t        state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] op_id_reg, op_id_next;
  logic          op_clr_reg, op_clr_next;
  logic [N-1:0]  op_data_reg, op_data_next;
  logic [R-1:0]  ack_reg, ack_next;
  logic          reg_ce_reg, reg_ce_next;
  logic          reg_rst_reg, reg_rst_next;
  logic [N-1:0]  reg_d_reg, reg_d_next;
  logic          busy_reg, busy_next;
  logic [IW-1:0] last_id_reg, last_id_next;

  logic [R-1:0]  pick_grant;
  logic [IW-1:0] pick_w;
  logic          pick_any;
  logic          pick_clr;
  logic [N-1:0]  wdata_arr [R];

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_slice
      assign wdata_arr[gi] = wdata[gi*N +: N];
    end
  endgenerate

  rr_priority_pick #(.R(R)) u_pick (
    .req     (req),
    .ptr     (ptr_reg),
    .grant   (pick_grant),
    .w       (pick_w),
    .any_req (pick_any)
  );

  assign pick_clr = |(clr & pick_grant);

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    op_id_next   = op_id_reg;
    op_clr_next  = op_clr_reg;
    op_data_next = op_data_reg;
    ack_next     = '0;
    reg_ce_next  = 1'b0;
    reg_rst_next = 1'b0;
    reg_d_next   = reg_d_reg;
    last_id_next = last_id_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          // Commit point: the operation is latched and will finish regardless of req.
          op_id_next   = pick_w;
          op_clr_next  = pick_clr;
          op_data_next = wdata_arr[pick_w];
          state_next   = ISSUE;
          reg_ce_next  = 1'b1;
          reg_rst_next = pick_clr;
          reg_d_next   = (pick_clr == OP_LOAD) ? wdata_arr[pick_w] : '0;
        end
      end
      ISSUE: begin
        state_next   = ACK;
        ack_next     = ONE_HOT_0 << op_id_reg;
        last_id_next = op_id_reg;
        ptr_next     = (op_id_reg == IW'(R - 1)) ? '0 : op_id_reg + 1'b1;
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State, operation and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      op_id_reg   <= '0;
      op_clr_reg  <= 1'b0;
      op_data_reg <= '0;
      ack_reg     <= '0;
      reg_ce_reg  <= 1'b0;
      reg_rst_reg <= 1'b0;
      reg_d_reg   <= '0;
      busy_reg    <= 1'b0;
      last_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      op_id_reg   <= op_id_next;
      op_clr_reg  <= op_clr_next;
      op_data_reg <= op_data_next;
      ack_reg     <= ack_next;
      reg_ce_reg  <= reg_ce_next;
      reg_rst_reg <= reg_rst_next;
      reg_d_reg   <= reg_d_next;
      busy_reg    <= busy_next;
      last_id_reg <= last_id_next;
    end
  end

  assign ack     = ack_reg;
  assign reg_ce  = reg_ce_reg;
  assign reg_rst = reg_rst_reg;
  assign reg_d   = reg_d_reg;
  assign busy    = busy_reg;
  assign last_id = last_id_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: stimulus pushes expected register
// updates and acks with their cycle stamps, a monitor pops and compares.
module tb_reg_write_arbiter;

  localparam int N  = 32;
  localparam int R  = 4;
  localparam int IW = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [R-1:0]    req;
  logic [R-1:0]    clr;
  logic [R*N-1:0]  wdata;
  logic [R-1:0]    ack;
  logic            reg_ce;
  logic            reg_rst;
  logic [N-1:0]    reg_d;
  logic            busy;
  logic [IW-1:0]   last_id;

  reg_write_arbiter #(.N(N), .R(R)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .clr     (clr),
    .wdata   (wdata),
    .ack     (ack),
    .reg_ce  (reg_ce),
    .reg_rst (reg_rst),
    .reg_d   (reg_d),
    .busy    (busy),
    .last_id (last_id)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit            is_ack;
    int            at;
    logic [N-1:0]  d;
    logic          rst;
    logic [R-1:0]  ackv;
    logic [IW-1:0] id;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every reg_ce or ack cycle must match the head of the scoreboard.
  always @(negedge clock) begin
    ev_t e;
    if (reg_ce || ack != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {59'b0, reg_ce, ack}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] cyc %0d %s ce=%b rst=%b d=%h ack=%b last_id=%0d",
                 cyc, reg_ce ? "issue" : "ack  ", reg_ce, reg_rst, reg_d, ack, last_id);
        check("event_kind", {63'b0, !reg_ce}, {63'b0, e.is_ack});
        check("event_cycle", 64'(cyc), 64'(e.at));
        check("busy_during_op", {63'b0, busy}, 64'd1);
        if (e.is_ack) begin
          check("ack_vector", {60'b0, ack}, {60'b0, e.ackv});
          check("last_id", {62'b0, last_id}, {62'b0, e.id});
          check("rst_low_in_ack", {63'b0, reg_rst}, 64'd0);
        end else begin
          check("reg_d", {32'b0, reg_d}, {32'b0, e.d});
          check("reg_rst", {63'b0, reg_rst}, {63'b0, e.rst});
          check("ack_low_in_issue", {60'b0, ack}, 64'd0);
        end
      end
    end
  end

  // Advance one cycle; a requester drops req as soon as it sees its ack.
  task automatic tick();
    @(negedge clock);
    for (int i = 0; i < R; i++) begin
      if (ack[i]) req[i] = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_w(input int i, input logic [N-1:0] v);
    wdata[i*N +: N] = v;
  endtask

  task automatic expect_op(input int id, input logic c, input logic [N-1:0] d,
                           input int at, input bit with_ack);
    ev_t e;
    e.is_ack = 1'b0;
    e.at     = at;
    e.d      = c ? '0 : d;
    e.rst    = c;
    e.ackv   = '0;
    e.id     = '0;
    exp_q.push_back(e);
    if (with_ack) begin
      e.is_ack = 1'b1;
      e.at     = at + 1;
      e.d      = '0;
      e.rst    = 1'b0;
      e.ackv   = R'(1) << id;
      e.id     = IW'(id);
      exp_q.push_back(e);
    end
  endtask

  int           base;
  logic [N-1:0] v;

  initial begin
    req   = '0;
    clr   = '0;
    wdata = '0;
    reset = 1'b1;
    ticks(3);
    check("rst_ack", {60'b0, ack}, 64'd0);
    check("rst_reg_ce", {63'b0, reg_ce}, 64'd0);
    check("rst_reg_rst", {63'b0, reg_rst}, 64'd0);
    check("rst_reg_d", {32'b0, reg_d}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_last_id", {62'b0, last_id}, 64'd0);
    reset = 1'b0;
    tick();

    // Load of a negative value by requester 0.
    set_w(0, 32'hFFFF_FFF6);
    req = 4'b0001;
    expect_op(0, 1'b0, 32'hFFFF_FFF6, cyc + 1, 1'b1);
    ticks(3);
    check("idle_after_load", {63'b0, busy}, 64'd0);

    // Requester 1 drops req during ISSUE; the committed op still completes.
    set_w(1, 32'h0000_00AA);
    req = 4'b0010;
    expect_op(1, 1'b0, 32'h0000_00AA, cyc + 1, 1'b1);
    tick();
    req[1] = 1'b0;
    ticks(2);
    check("idle_after_drop", {63'b0, busy}, 64'd0);
    tick();
    check("no_regrant_after_drop", {63'b0, busy}, 64'd0);

    // Clear by requester 2: data must be forced to zero.
    set_w(2, 32'h1234_5678);
    set_w(0, 32'h5555_5555);
    clr = 4'b0100;
    req = 4'b0100;
    expect_op(2, 1'b1, 32'h1234_5678, cyc + 1, 1'b1);
    ticks(3);
    clr = '0;

    // ptr=3 with req 1001: 3 first, then 0 (wrap).
    set_w(3, 32'h8000_0000);
    set_w(0, 32'h0000_0001);
    req = 4'b1001;
    expect_op(3, 1'b0, 32'h8000_0000, cyc + 1, 1'b1);
    expect_op(0, 1'b0, 32'h0000_0001, cyc + 4, 1'b1);
    ticks(6);

    // ptr should now be 1: with 0 and 1 requesting, 1 wins.
    set_w(0, 32'h0000_0002);
    set_w(1, 32'hFFFF_0000);
    req = 4'b0011;
    expect_op(1, 1'b0, 32'hFFFF_0000, cyc + 1, 1'b1);
    expect_op(0, 1'b0, 32'h0000_0002, cyc + 4, 1'b1);
    ticks(6);

    // Serve requester 3 alone so the pointer returns to 0.
    set_w(3, 32'h7FFF_FFFF);
    req = 4'b1000;
    expect_op(3, 1'b0, 32'h7FFF_FFFF, cyc + 1, 1'b1);
    ticks(3);

    // All four requesting, two rounds: order 0,1,2,3 every 3 cycles.
    for (int round = 0; round < 2; round++) begin
      base = cyc;
      for (int i = 0; i < R; i++) begin
        v = 32'hC0DE_0000 | 32'(round * 16 + i);
        set_w(i, v);
        expect_op(i, 1'b0, v, base + 1 + 3 * i, 1'b1);
      end
      req = 4'b1111;
      ticks(12);
    end

    // Serve requester 1 so ptr=2 and last_id=1 before the reset test.
    set_w(1, 32'h0F0F_0F0F);
    req = 4'b0010;
    expect_op(1, 1'b0, 32'h0F0F_0F0F, cyc + 1, 1'b1);
    ticks(3);

    // Reset during ISSUE: no ack, everything back to reset values.
    set_w(2, 32'hDEAD_BEEF);
    set_w(0, 32'h0000_00C3);
    req = 4'b0100;
    expect_op(2, 1'b0, 32'hDEAD_BEEF, cyc + 1, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_reg_ce", {63'b0, reg_ce}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_ack", {60'b0, ack}, 64'd0);
    check("midrst_reg_d", {32'b0, reg_d}, 64'd0);
    check("midrst_last_id", {62'b0, last_id}, 64'd0);
    reset = 1'b0;
    // ptr reset to 0, so 0 wins over the still-pending 2; 2 follows with full latency.
    req = 4'b0101;
    expect_op(0, 1'b0, 32'h0000_00C3, cyc + 1, 1'b1);
    expect_op(2, 1'b0, 32'hDEAD_BEEF, cyc + 4, 1'b1);
    ticks(6);

    ticks(2);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
